// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pad; resets to the idle-high line level.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic [1:0] r_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[0], i_async};
    end
  end

  assign o_sync = r_sync[1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: mid-bit sampling, LSB-first assembly, valid/ready output with error pulses.
// Optional parity bit enabled by defining UART_RX_PARITY_EN.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_receiver: unsupported parameter combination");
  end

  uart_state_t          r_state, w_state_next;
  logic [CW-1:0]        r_clk_cnt, w_clk_cnt_next;
  logic [IW-1:0]        r_bit_idx, w_bit_idx_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic [DATA_BITS-1:0] r_data, w_data_next;
  logic                 r_valid, w_valid_next;
  logic                 r_frame_err, w_frame_err_next;
  logic                 r_parity_err, w_parity_err_next;
  logic                 r_overrun_err, w_overrun_err_next;
  logic                 r_rx_prev;
  logic                 w_rx_sync;
  logic                 w_start;
  logic                 w_accept;
  logic                 w_bit_done;
  logic                 w_par_bad;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (rx),
    .o_sync  (w_rx_sync)
  );

  assign w_start    = r_rx_prev & ~w_rx_sync;
  assign w_accept   = r_valid & rx_ready;
  assign w_bit_done = (r_clk_cnt == FULL_M1);

`ifdef UART_RX_PARITY_EN
  localparam logic P_ODD = (PARITY_ODD != 0);
  logic r_par_bit, w_par_bit_next;

  assign w_par_bad = ((^r_shift) ^ P_ODD) != r_par_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_par_bit <= 1'b0;
    end else begin
      r_par_bit <= w_par_bit_next;
    end
  end
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_clk_cnt     <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_frame_err   <= 1'b0;
      r_parity_err  <= 1'b0;
      r_overrun_err <= 1'b0;
      r_rx_prev     <= 1'b1;
    end else begin
      r_state       <= w_state_next;
      r_clk_cnt     <= w_clk_cnt_next;
      r_bit_idx     <= w_bit_idx_next;
      r_shift       <= w_shift_next;
      r_data        <= w_data_next;
      r_valid       <= w_valid_next;
      r_frame_err   <= w_frame_err_next;
      r_parity_err  <= w_parity_err_next;
      r_overrun_err <= w_overrun_err_next;
      r_rx_prev     <= w_rx_sync;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_clk_cnt_next     = r_clk_cnt;
    w_bit_idx_next     = r_bit_idx;
    w_shift_next       = r_shift;
    w_data_next        = r_data;
    w_valid_next       = r_valid & ~w_accept;
    w_frame_err_next   = 1'b0;
    w_parity_err_next  = 1'b0;
    w_overrun_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bit_next     = r_par_bit;
`endif

    case (r_state)
      IDLE: begin
        w_clk_cnt_next = '0;
        w_bit_idx_next = '0;
        if (w_start) w_state_next = START;
      end
      START: begin
        if (r_clk_cnt == HALF_M1) begin
          w_clk_cnt_next = '0;
          w_state_next   = w_rx_sync ? IDLE : DATA;
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (w_bit_done) begin
          w_clk_cnt_next = '0;
          w_shift_next   = {w_rx_sync, r_shift[DATA_BITS-1:1]};
          if (r_bit_idx == LAST_IDX) begin
            w_bit_idx_next = '0;
`ifdef UART_RX_PARITY_EN
            w_state_next   = PARITY;
`else
            w_state_next   = STOP;
`endif
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_bit_done) begin
          w_clk_cnt_next = '0;
          w_par_bit_next = w_rx_sync;
          w_state_next   = STOP;
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_bit_done) begin
          w_clk_cnt_next = '0;
          w_state_next   = IDLE;
          // Error precedence: framing, then parity, then overrun; a same-cycle handshake frees the slot.
          if (!w_rx_sync) begin
            w_frame_err_next = 1'b1;
          end else if (w_par_bad) begin
            w_parity_err_next = 1'b1;
          end else if (r_valid && !w_accept) begin
            w_overrun_err_next = 1'b1;
          end else begin
            w_data_next  = r_shift;
            w_valid_next = 1'b1;
          end
        end else begin
          w_clk_cnt_next = r_clk_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next   = IDLE;
        w_clk_cnt_next = '0;
        w_bit_idx_next = '0;
      end
    endcase
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign busy        = (r_state != IDLE);
  assign frame_err   = r_frame_err;
  assign parity_err  = r_parity_err;
  assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table of frames plus hand-written corner sequences.
module tb_uart_receiver;

  localparam int CPB = 16;
  localparam int DB  = 8;

  logic          clk;
  logic          reset;
  logic          rx;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          busy;
  logic          frame_err;
  logic          parity_err;
  logic          overrun_err;

  uart_receiver #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .PARITY_ODD   (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .busy        (busy),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_valid;
    int         exp_frame;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int n_valid, n_frame, n_parity, n_overrun;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic clear_counts();
    n_valid = 0; n_frame = 0; n_parity = 0; n_overrun = 0;
  endtask

  // One clock: observe outputs at negedge, then step past the next posedge.
  task automatic tick();
    @(negedge clk);
    if (rx_valid)    n_valid++;
    if (frame_err)   n_frame++;
    if (parity_err)  n_parity++;
    if (overrun_err) n_overrun++;
    if (rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid got=%0h required=none", rx_data);
      end else begin
        check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic bad_par);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      repeat (CPB) tick();
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ bad_par;
    repeat (CPB) tick();
`else
    if (bad_par) rx = 1'b1;
`endif
    rx = stop;
    repeat (CPB) tick();
    rx = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h01, 1'b1, 1, 0};
    vecs[2] = '{8'h6E, 1'b1, 1, 0};
    vecs[3] = '{8'h00, 1'b1, 1, 0};
    vecs[4] = '{8'hFF, 1'b1, 1, 0};
    vecs[5] = '{8'h3C, 1'b0, 0, 1};
    vecs[6] = '{8'hC8, 1'b1, 1, 0};

    rx = 1'b1;
    rx_ready = 1'b1;
    reset = 1'b1;
    clear_counts();
    repeat (3) tick();
    reset = 1'b0;
    check("reset_busy",   {31'h0, busy},     0);
    check("reset_valid",  {31'h0, rx_valid}, 0);
    check("reset_data",   {24'h0, rx_data},  0);
    check("reset_errors", {29'h0, frame_err, parity_err, overrun_err}, 0);
    idle(10);

    for (int v = 0; v < 7; v++) begin
      clear_counts();
      if (vecs[v].exp_valid != 0) exp_q.push_back(vecs[v].data);
      send(vecs[v].data, vecs[v].stop, 1'b0);
      idle(30);
      check("vec_valid_cycles", n_valid, vecs[v].exp_valid);
      check("vec_frame_err",    n_frame, vecs[v].exp_frame);
      check("vec_overrun",      n_overrun, 0);
      check("vec_parity",       n_parity, 0);
      check("vec_delivered",    exp_q.size(), 0);
    end

    // Short low glitch: start rejected without error.
    clear_counts();
    rx = 1'b0;
    repeat (6) tick();
    idle(40);
    check("glitch_valid", n_valid, 0);
    check("glitch_frame", n_frame, 0);
    check("glitch_busy",  {31'h0, busy}, 0);

    // Bad stop bit followed by a held break: exactly one framing error.
    clear_counts();
    send(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (100) tick();
    check("break_busy", {31'h0, busy}, 0);
    idle(30);
    check("break_frame_pulses", n_frame, 1);
    check("break_valid",        n_valid, 0);

    // Overrun: first word held while consumer stalls, second word dropped.
    clear_counts();
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1, 1'b0);
    idle(20);
    check("ovr_valid_held", {31'h0, rx_valid}, 1);
    check("ovr_data_first", {24'h0, rx_data}, 32'h11);
    send(8'h22, 1'b1, 1'b0);
    idle(20);
    check("ovr_pulse",     n_overrun, 1);
    check("ovr_data_kept", {24'h0, rx_data}, 32'h11);
    rx_ready = 1'b1;
    repeat (3) tick();
    check("ovr_valid_drop", {31'h0, rx_valid}, 0);
    check("ovr_delivered",  exp_q.size(), 0);

    // Reset in the middle of data bit 4 of 0xFF, then a clean 0x5A.
    clear_counts();
    rx = 1'b0;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (4 * CPB + CPB / 2) tick();
    check("mid_busy_before", {31'h0, busy}, 1);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("mid_busy_after", {31'h0, busy}, 0);
    idle(6 * CPB);
    exp_q.push_back(8'h5A);
    send(8'h5A, 1'b1, 1'b0);
    idle(30);
    check("mid_valid_cycles", n_valid, 1);
    check("mid_frame",        n_frame, 0);
    check("mid_delivered",    exp_q.size(), 0);

`ifdef UART_RX_PARITY_EN
    clear_counts();
    exp_q.push_back(8'h07);
    send(8'h07, 1'b1, 1'b0);
    idle(30);
    check("par_good_valid", n_valid, 1);
    check("par_good_err",   n_parity, 0);
    check("par_delivered",  exp_q.size(), 0);
    clear_counts();
    send(8'h07, 1'b1, 1'b1);
    idle(30);
    check("par_bad_err",   n_parity, 1);
    check("par_bad_valid", n_valid, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
